// File: rtl/snake_move_ctrl.sv
// Snake head movement controller: steps the head one cell every TICK_DIV cycles, detects wall hits.
// Latency: position/head_dir update on the step-cycle edge; step_pulse high the cycle after that edge.
// Backpressure: none; pause freezes the tick counter and movement, and reversal requests are dropped.
module snake_move_ctrl #(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int START_X  = 5,
    parameter int START_Y  = 5,
    parameter int TICK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       dir_valid,
    input  logic [1:0] dir_req,
    output logic [9:0] x_cell,
    output logic [9:0] y_cell,
    output logic [1:0] head_dir,
    output logic       step_pulse,
    output logic       game_over,
    output logic [1:0] state
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [9:0] X_MAX = 10'(GRID_W - 1);
    localparam logic [9:0] Y_MAX = 10'(GRID_H - 1);
    localparam logic [9:0] SX    = 10'(START_X);
    localparam logic [9:0] SY    = 10'(START_Y);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    state_t        st;
    logic [1:0]    pend;
    logic [CW-1:0] cnt;
    logic [9:0]    nx;
    logic [9:0]    ny;
    logic          hit_wall;
    logic          dir_ok;

    assign state = st;

    // Next cell and wall test from the unwrapped current position, so an edge cell
    // is detected before any 10-bit underflow/overflow can appear.
    always_comb begin
        nx       = x_cell;
        ny       = y_cell;
        hit_wall = 1'b0;
        case (pend)
            2'd0: begin ny = y_cell - 10'd1; hit_wall = (y_cell == 10'd0); end
            2'd1: begin nx = x_cell + 10'd1; hit_wall = (x_cell == X_MAX); end
            2'd2: begin ny = y_cell + 10'd1; hit_wall = (y_cell == Y_MAX); end
            default: begin nx = x_cell - 10'd1; hit_wall = (x_cell == 10'd0); end
        endcase
    end

    // A request is taken unless it reverses the committed direction; ignored once dead.
    assign dir_ok = dir_valid && (st != S_DEAD) && (dir_req != (head_dir ^ 2'd2));

    // Game FSM, tick counter, head position and pending direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= S_IDLE;
            x_cell     <= SX;
            y_cell     <= SY;
            head_dir   <= 2'd1;
            pend       <= 2'd1;
            cnt        <= '0;
            step_pulse <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            // The step below reads the old pend, so a request on a step cycle waits for the next step.
            if (dir_ok) begin
                pend <= dir_req;
            end
            case (st)
                S_IDLE: begin
                    if (start) begin
                        st  <= S_RUN;
                        cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        st <= S_PAUSE;
                    end else if (cnt == TICK_LAST) begin
                        cnt <= '0;
                        if (hit_wall) begin
                            st        <= S_DEAD;
                            game_over <= 1'b1;
                        end else begin
                            x_cell     <= nx;
                            y_cell     <= ny;
                            head_dir   <= pend;
                            step_pulse <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (!pause) begin
                        st <= S_RUN;
                    end
                end
                default: begin
                    if (start) begin
                        st        <= S_RUN;
                        game_over <= 1'b0;
                        x_cell    <= SX;
                        y_cell    <= SY;
                        head_dir  <= 2'd1;
                        pend      <= 2'd1;
                        cnt       <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/snake_move_ctrl.md
SNAKE_MOVE_CTRL -- requirements
Module: snake_move_ctrl

Interface
REQ-001 SHALL have parameter GRID_W, default 40, meaning grid width in cells.
REQ-002 SHALL have parameter GRID_H, default 30, meaning grid height in cells.
REQ-003 SHALL have parameter START_X, default 5, meaning head x cell after reset or restart.
REQ-004 SHALL have parameter START_Y, default 5, meaning head y cell after reset or restart.
REQ-005 SHALL have parameter TICK_DIV, default 12500000, meaning clk cycles per movement step (>=2).
REQ-006 SHALL have port clk  input  1  system clock (CLOCK_50); single clock domain; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port start  input  1  one-cycle request to begin or restart play.
REQ-009 SHALL have port pause  input  1  level; high freezes movement while running.
REQ-010 SHALL have port dir_valid  input  1  qualifies dir_req this cycle.
REQ-011 SHALL have port dir_req  input  2  requested direction: 0 up, 1 right, 2 down, 3 left.
REQ-012 SHALL have port x_cell  output  10  registered head x cell.
REQ-013 SHALL have port y_cell  output  10  registered head y cell.
REQ-014 SHALL have port head_dir  output  2  registered direction of the last committed step.
REQ-015 SHALL have port step_pulse  output  1  high for one cycle when the head moves.
REQ-016 SHALL have port game_over  output  1  high while in DEAD.
REQ-017 SHALL have port state  output  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DEAD.

Function
REQ-018 FSM SHALL go IDLE->RUN on start; RUN->PAUSE on pause=1; PAUSE->RUN on pause=0; RUN->DEAD on wall collision; DEAD->RUN on start.
REQ-019 In RUN with pause=0, the tick counter SHALL count 0..TICK_DIV-1 and then wrap; the cycle it holds TICK_DIV-1 is the step cycle.
REQ-020 A RUN cycle with pause=1 SHALL neither increment the counter nor step; the counter holds its value through PAUSE and resumes from it.
REQ-021 On a step cycle the next cell SHALL be computed from pending direction: up y-1, right x+1, down y+1, left x-1.
REQ-022 If the next cell is in range (0..GRID_W-1, 0..GRID_H-1), x_cell/y_cell SHALL update on that edge, head_dir SHALL take the pending direction, and step_pulse SHALL be 1 in the following cycle only.
REQ-023 If the next cell is out of range (x=0 left, x=GRID_W-1 right, y=0 up, y=GRID_H-1 down), position and head_dir SHALL hold, step_pulse SHALL stay 0, and state SHALL become DEAD.
REQ-024 Out-of-range detection SHALL use the unwrapped current position, never a wrapped or 10-bit-overflowed value.
REQ-025 dir_req with dir_valid SHALL be accepted into pending direction in IDLE, RUN or PAUSE unless it equals head_dir XOR 2; reversals SHALL be silently dropped.
REQ-026 A request arriving on a step cycle SHALL NOT affect that step; it is registered for the next step and checked against the pre-step head_dir.
REQ-027 Multiple accepted requests between steps: the last one SHALL win.
REQ-028 dir_valid SHALL be ignored in DEAD.
REQ-029 start in DEAD SHALL reload x_cell=START_X, y_cell=START_Y, head_dir=1, pending=1, counter=0, and enter RUN on the next edge.
REQ-030 start in RUN or PAUSE SHALL be ignored; start coincident with a collision step SHALL be ignored (DEAD wins).
REQ-031 game_over SHALL be 1 exactly when state=3.

Reset
REQ-032 reset=1 SHALL on the next edge set state=IDLE, x_cell=START_X, y_cell=START_Y, head_dir=1, pending=1, counter=0, step_pulse=0, game_over=0.
REQ-033 reset SHALL take priority over every other input, including mid-step and in DEAD.

Verification (TICK_DIV=4)
REQ-034 reset, then start -> state=1; step_pulse every 4 cycles; x_cell 5,6,7 with y_cell=5.
REQ-035 In RUN, dir_req=3 with dir_valid (head_dir=1) -> dropped; next step gives x_cell+1.
REQ-036 dir_req=2, then dir_req=3, both before the next step -> the step moves down (y 5->6); a later dir_req=3 is accepted.
REQ-037 pause=1 for 10 cycles with counter=2 -> no step_pulse; after release, the step occurs 2 cycles later.
REQ-038 Run right from x=38 -> one step to x=39; the next step gives state=3, game_over=1, x_cell=39, step_pulse=0; start -> (5,5), head_dir=1, state=1.
REQ-039 reset asserted on a step cycle -> no step_pulse, (5,5), state=0.
